// File: rtl/timer_if.sv
// Register-bus signals between the data-memory bridge and the timer device.
interface timer_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, we, wdata, input rdata, irq);
    modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped 32-bit down-counting timer with one-shot / auto-reload modes
// and a sticky pending flag gated onto irq by the CTRL mask bit.
module timer_dev (
    input  logic    clk,
    input  logic    rst,
    timer_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;
    localparam logic [1:0]  A_CTRL   = 2'd0;
    localparam logic [1:0]  A_PRESET = 2'd1;
    localparam logic [1:0]  A_COUNT  = 2'd2;
    localparam logic [1:0]  M_RELOAD = 2'b01;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t              state_q, state_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   preset_q, preset_d;
    logic [DATA_W-1:0]   count_q, count_d;
    logic                pending_q, pending_d;
    logic                wr_ctrl, wr_preset, auto_reload;
    logic [DATA_W-1:0]   rdata_c;

    // State and register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // Next-state and register updates; ordering sets priority between
    // software writes and FSM actions (CTRL write beats one-shot en clear,
    // INT pending set beats the write clear).
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        preset_d    = preset_q;
        count_d     = count_q;
        pending_d   = pending_q;
        wr_ctrl     = bus.we && (bus.addr == A_CTRL);
        wr_preset   = bus.we && (bus.addr == A_PRESET);
        auto_reload = (ctrl_q.mode == M_RELOAD);

        if (wr_preset) preset_d = bus.wdata;
        if (wr_ctrl || wr_preset) pending_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl_q.en) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                if (auto_reload) pending_d = 1'b0;
                state_d = ctrl_q.en ? S_CNT : S_IDLE;
            end
            S_CNT: begin
                if (!ctrl_q.en)           state_d = S_IDLE;
                else if (count_q != '0)   count_d = count_q - DATA_W'(1);
                else                      state_d = S_INT;
            end
            S_INT: begin
                pending_d = 1'b1;
                if (auto_reload && ctrl_q.en) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                    if (!auto_reload) ctrl_d.en = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_ctrl) ctrl_d = ctrl_t'(bus.wdata[CTRL_W-1:0]);
    end

    // Combinational register read
    always_comb begin
        rdata_c = '0;
        case (bus.addr)
            A_CTRL:   rdata_c = {(DATA_W-CTRL_W)'(0), ctrl_q};
            A_PRESET: rdata_c = preset_q;
            A_COUNT:  rdata_c = count_q;
            default:  rdata_c = '0;
        endcase
    end

    assign bus.rdata = rdata_c;
    assign bus.irq   = ctrl_q.im & pending_q;
endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: reset, one-shot, auto-reload, stop/resume,
// INT-cycle write, masking and PRESET=0 with hand-computed expectations.
module tb_timer_dev;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    timer_if bus ();

    timer_dev dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.we    = 1'b1;
        bus.wdata = d;
        tick(1);
        bus.we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk_eq(tag, bus.rdata, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        chk_eq(tag, 32'(bus.irq), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr  = 2'd0;
        bus.we    = 1'b0;
        bus.wdata = '0;

        // Reset state
        #12;
        irq_chk("rst_irq", 1'b0);
        rd_chk("rst_ctrl", 2'd0, 32'h0);
        rd_chk("rst_preset", 2'd1, 32'h0);
        rd_chk("rst_count", 2'd2, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick(1);

        // One-shot, PRESET=3
        wr(2'd1, 32'd3);
        rd_chk("os_preset", 2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick(1);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            rd_chk($sformatf("os_count_e%0d", k + 2), 2'd2, 32'(3 - k));
        end
        tick(1);
        irq_chk("os_irq_e6", 1'b0);
        tick(1);
        irq_chk("os_irq_e7", 1'b1);
        tick(3);
        irq_chk("os_irq_hold", 1'b1);
        rd_chk("os_ctrl", 2'd0, 32'h8);
        rd_chk("os_rsvd", 2'd3, 32'h0);
        wr(2'd1, 32'd5);
        irq_chk("os_preset_clr", 1'b0);
        wr(2'd2, 32'hdead);
        rd_chk("os_count_ro", 2'd2, 32'h0);

        // Auto-reload, PRESET=2: pulses at E6, E11, E16
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int e = 1; e <= 17; e++) begin
            tick(1);
            irq_chk($sformatf("ar_irq_e%0d", e), (e == 6 || e == 11 || e == 16));
            if (e == 2 || e == 7 || e == 12)
                rd_chk($sformatf("ar_count_e%0d", e), 2'd2, 32'd2);
        end
        wr(2'd0, 32'h8);
        tick(3);

        // Stop at COUNT=6 and resume
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(5);
        rd_chk("ss_count_e5", 2'd2, 32'd7);
        wr(2'd0, 32'h8);
        rd_chk("ss_count_e6", 2'd2, 32'd6);
        tick(4);
        rd_chk("ss_count_held", 2'd2, 32'd6);
        irq_chk("ss_irq", 1'b0);
        rd_chk("ss_ctrl", 2'd0, 32'h8);
        wr(2'd0, 32'h9);
        tick(2);
        rd_chk("ss_reload", 2'd2, 32'd10);

        // CTRL=0x9 written in the INT cycle (INT occupies F13..F14)
        tick(11);
        irq_chk("si_irq_pre", 1'b0);
        rd_chk("si_count_zero", 2'd2, 32'd0);
        wr(2'd0, 32'h9);
        irq_chk("si_irq_set", 1'b1);
        rd_chk("si_ctrl_en", 2'd0, 32'h9);
        tick(2);
        rd_chk("si_restart", 2'd2, 32'd10);
        irq_chk("si_irq_sticky", 1'b1);
        wr(2'd0, 32'h0);
        irq_chk("si_irq_clr", 1'b0);
        tick(2);

        // Masked interrupt, PRESET=1, im=0
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        tick(5);
        irq_chk("mk_irq_e5", 1'b0);
        tick(1);
        rd_chk("mk_ctrl", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        irq_chk("mk_unmask", 1'b0);
        tick(1);
        irq_chk("mk_unmask2", 1'b0);

        // PRESET=0
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(1);
        irq_chk("p0_irq_e1", 1'b0);
        tick(1);
        rd_chk("p0_count_e2", 2'd2, 32'd0);
        tick(1);
        rd_chk("p0_count_e3", 2'd2, 32'd0);
        irq_chk("p0_irq_e3", 1'b0);
        tick(1);
        irq_chk("p0_irq_e4", 1'b1);
        rd_chk("p0_count_e4", 2'd2, 32'd0);
        tick(1);
        rd_chk("p0_count_e5", 2'd2, 32'd0);
        rd_chk("p0_ctrl", 2'd0, 32'h8);

        // Asynchronous reset with irq high mid-run (auto-reload, PRESET=2)
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        tick(6);
        irq_chk("ar_rst_pre", 1'b1);
        rst = 1'b0;
        #1;
        irq_chk("ar_rst_irq", 1'b0);
        rd_chk("ar_rst_ctrl", 2'd0, 32'h0);
        rd_chk("ar_rst_preset", 2'd1, 32'h0);
        rd_chk("ar_rst_count", 2'd2, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick(5);
        rd_chk("ar_post_count", 2'd2, 32'h0);
        rd_chk("ar_post_ctrl", 2'd0, 32'h0);
        irq_chk("ar_post_irq", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
